// File: rtl/cmd_pkg.sv
// Shared definitions for the 3-byte command link.
// Used by the host-side master and the vehicle-side receiver.
package cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND_CMD,
        SEND_HI,
        SEND_LO,
        WAIT_RESP
    } master_state_t;

    // Wire order of the three frame bytes
    localparam logic [1:0] BYTE_CMD = 2'd0;
    localparam logic [1:0] BYTE_HI  = 2'd1;
    localparam logic [1:0] BYTE_LO  = 2'd2;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_READ   = 8'h01;
    localparam logic [7:0] OP_WRITE  = 8'h02;
    localparam logic [7:0] OP_STATUS = 8'h03;

    // Byte to be loaded on the next trmt, given the current state
    function automatic logic [1:0] next_byte_sel(input master_state_t st);
        case (st)
            SEND_CMD: return BYTE_HI;
            SEND_HI:  return BYTE_LO;
            default:  return BYTE_CMD;
        endcase
    endfunction

endpackage

// File: rtl/uart_cmd_master_if.sv
// Host-facing command/response handshake of uart_cmd_master.
// master = command issuer, slave = uart_cmd_master.
interface uart_cmd_master_if;
    logic        snd_cmd;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        clr_resp_rdy;
    logic        busy;
    logic        cmd_sent;
    logic [7:0]  resp;
    logic        resp_rdy;
    logic        timeout;

    modport master (
        output snd_cmd, cmd, data, clr_resp_rdy,
        input  busy, cmd_sent, resp, resp_rdy, timeout
    );

    modport slave (
        input  snd_cmd, cmd, data, clr_resp_rdy,
        output busy, cmd_sent, resp, resp_rdy, timeout
    );
endinterface

// File: rtl/uart_cmd_master_uart.sv
// 8N1 UART transmitter + receiver, BAUD_DIV clocks per bit.
// TX: start bit driven the cycle after trmt; tx_done rises at end of stop bit. RX: rx_rdy at mid stop bit.
// No backpressure: trmt while sending restarts the frame; a new RX byte overwrites rx_data.
module uart #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       TX,
    input  logic       RX,
    input  logic       clr_rx_rdy,
    output logic       rx_rdy,
    output logic [7:0] rx_data
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2 - 1);

    logic [9:0]    tx_shft;
    logic [CW-1:0] tx_baud;
    logic [3:0]    tx_bit;
    logic          tx_act;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shft <= '1;
            tx_baud <= '0;
            tx_bit  <= '0;
            tx_act  <= 1'b0;
            tx_done <= 1'b0;
        end else if (trmt) begin
            tx_shft <= {1'b1, tx_data, 1'b0};
            tx_baud <= '0;
            tx_bit  <= '0;
            tx_act  <= 1'b1;
            tx_done <= 1'b0;
        end else if (tx_act) begin
            if (tx_baud == BAUD_LAST) begin
                tx_baud <= '0;
                tx_shft <= {1'b1, tx_shft[9:1]};
                tx_bit  <= tx_bit + 4'd1;
                if (tx_bit == 4'd9) begin
                    tx_act  <= 1'b0;
                    tx_done <= 1'b1;
                end
            end else begin
                tx_baud <= tx_baud + CW'(1);
            end
        end
    end

    assign TX = tx_shft[0];

    logic          rx_m;
    logic          rx_s;
    logic [CW-1:0] rx_baud;
    logic [3:0]    rx_bit;
    logic          rx_act;
    logic [7:0]    rx_shft;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_baud <= '0;
            rx_bit  <= '0;
            rx_act  <= 1'b0;
            rx_shft <= '0;
            rx_data <= '0;
            rx_rdy  <= 1'b0;
        end else begin
            rx_m <= RX;
            rx_s <= rx_m;
            if (clr_rx_rdy) rx_rdy <= 1'b0;
            if (!rx_act) begin
                if (!rx_s) begin
                    rx_act  <= 1'b1;
                    rx_baud <= BAUD_HALF;
                    rx_bit  <= '0;
                end
            end else if (rx_baud != '0) begin
                rx_baud <= rx_baud - CW'(1);
            end else begin
                rx_baud <= BAUD_LAST;
                rx_bit  <= rx_bit + 4'd1;
                if (rx_bit == 4'd0) begin
                    // Start bit gone high at mid-bit: glitch, not a frame
                    if (rx_s) rx_act <= 1'b0;
                end else if (rx_bit == 4'd9) begin
                    rx_act <= 1'b0;
                    if (rx_s) begin
                        rx_data <= rx_shft;
                        rx_rdy  <= 1'b1;
                    end
                end else begin
                    rx_shft <= {rx_s, rx_shft[7:1]};
                end
            end
        end
    end

endmodule

// File: rtl/uart_cmd_master.sv
// Serializes {cmd,data} as three UART bytes (cmd, data hi, data lo) and captures a one-byte response.
// First trmt in the snd_cmd cycle; next byte one cycle after tx_done; busy drops the cycle after capture/timeout.
// snd_cmd is accepted only while idle (busy=0); requests while busy are dropped, not queued.
module uart_cmd_master
    import cmd_pkg::*;
#(
    parameter int RESP_TIMEOUT = 1_000_000,
    parameter int TMO_W        = 24,
    parameter int BAUD_DIV     = 434
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_cmd_master_if.slave  host,
    output logic              TX,
    input  logic              RX
);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((RESP_TIMEOUT == 0) ? 0 : RESP_TIMEOUT - 1);

    master_state_t    state_q, state_d;
    logic [7:0]       cmd_q;
    logic [15:0]      data_q;
    logic [TMO_W-1:0] tmo_cnt;
    logic             cmd_sent_q, resp_rdy_q, timeout_q;
    logic [7:0]       resp_q;

    logic       trmt, tx_done, rx_rdy, clr_rx_rdy;
    logic [7:0] tx_data, rx_data;
    logic [1:0] byte_sel;
    logic       accept, set_sent, capture, set_tmo, tmo_clr, tmo_inc;

    uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk        (clk),
        .rst_n      (rst_n),
        .trmt       (trmt),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .TX         (TX),
        .RX         (RX),
        .clr_rx_rdy (clr_rx_rdy),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // The cmd byte bypasses cmd_q on the accept cycle so trmt can fire immediately
    assign byte_sel = next_byte_sel(state_q);

    always_comb begin
        tx_data = cmd_q;
        case (byte_sel)
            BYTE_HI:  tx_data = data_q[15:8];
            BYTE_LO:  tx_data = data_q[7:0];
            default:  tx_data = (state_q == IDLE) ? host.cmd : cmd_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        trmt       = 1'b0;
        clr_rx_rdy = 1'b0;
        accept     = 1'b0;
        set_sent   = 1'b0;
        capture    = 1'b0;
        set_tmo    = 1'b0;
        tmo_clr    = 1'b0;
        tmo_inc    = 1'b0;
        case (state_q)
            IDLE: begin
                clr_rx_rdy = rx_rdy;
                if (host.snd_cmd) begin
                    accept  = 1'b1;
                    trmt    = 1'b1;
                    state_d = SEND_CMD;
                end
            end
            SEND_CMD: begin
                clr_rx_rdy = rx_rdy;
                if (tx_done) begin
                    trmt    = 1'b1;
                    state_d = SEND_HI;
                end
            end
            SEND_HI: begin
                clr_rx_rdy = rx_rdy;
                if (tx_done) begin
                    trmt    = 1'b1;
                    state_d = SEND_LO;
                end
            end
            SEND_LO: begin
                clr_rx_rdy = rx_rdy;
                if (tx_done) begin
                    set_sent = 1'b1;
                    tmo_clr  = 1'b1;
                    state_d  = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                // A response arriving on the expiry cycle still counts as a response
                if (rx_rdy) begin
                    capture    = 1'b1;
                    clr_rx_rdy = 1'b1;
                    state_d    = IDLE;
                end else if (RESP_TIMEOUT != 0 && tmo_cnt == TMO_LAST) begin
                    set_tmo = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q      <= '0;
            data_q     <= '0;
            tmo_cnt    <= '0;
            cmd_sent_q <= 1'b0;
            resp_q     <= '0;
            resp_rdy_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            if (accept) begin
                cmd_q  <= host.cmd;
                data_q <= host.data;
            end
            if (accept)        cmd_sent_q <= 1'b0;
            else if (set_sent) cmd_sent_q <= 1'b1;
            if (capture) resp_q <= rx_data;
            if (capture)                            resp_rdy_q <= 1'b1;
            else if (accept || host.clr_resp_rdy)   resp_rdy_q <= 1'b0;
            if (set_tmo)     timeout_q <= 1'b1;
            else if (accept) timeout_q <= 1'b0;
            if (tmo_clr)      tmo_cnt <= '0;
            else if (tmo_inc) tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    assign host.busy     = (state_q != IDLE);
    assign host.cmd_sent = cmd_sent_q;
    assign host.resp     = resp_q;
    assign host.resp_rdy = resp_rdy_q;
    assign host.timeout  = timeout_q;

endmodule

// File: tb/tb_uart_cmd_master.sv
// Directed bench for uart_cmd_master: table of command/response vectors plus busy, stray-byte and reset sequences.
module tb_uart_cmd_master;
    localparam int BAUD_DIV     = 8;
    localparam int RESP_TIMEOUT = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    logic tx;

    uart_cmd_master_if bus();

    uart_cmd_master #(
        .RESP_TIMEOUT (RESP_TIMEOUT),
        .TMO_W        (24),
        .BAUD_DIV     (BAUD_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .host  (bus),
        .TX    (tx),
        .RX    (rx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] wire_q[$];

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] data;
        bit          do_resp;
        logic [7:0]  rx_byte;
        logic [7:0]  w0, w1, w2;
        logic [7:0]  exp_resp;
        bit          exp_rdy;
        bit          exp_tmo;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit cond(input int which);
        case (which)
            0:       return bus.cmd_sent;
            1:       return bus.resp_rdy;
            2:       return bus.timeout;
            default: return (wire_q.size() >= 1);
        endcase
    endfunction

    task automatic wait_for(input int which, input int max, input string name, output int cyc);
        cyc = 0;
        while (!cond(which) && cyc < max) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!cond(which)) begin
            errors++;
            $display("FAIL %s: not reached within %0d cycles, required reached", name, max);
        end
    endtask

    function automatic logic [7:0] byte_at(input int k);
        if (wire_q.size() > k) return wire_q[k];
        return 8'hEE;
    endfunction

    // Decode 8N1 bytes from TX, sampling mid-bit on falling clock edges
    initial begin : tx_monitor
        logic [7:0] b;
        b = '0;
        forever begin
            @(negedge tx);
            repeat (BAUD_DIV / 2) @(negedge clk);
            if (tx == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD_DIV) @(negedge clk);
                    b[i] = tx;
                end
                repeat (BAUD_DIV) @(negedge clk);
                wire_q.push_back(b);
            end
        end
    end

    task automatic send_rx(input logic [7:0] b);
        rx = 1'b0;
        repeat (BAUD_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BAUD_DIV) @(negedge clk);
        end
        rx = 1'b1;
        repeat (BAUD_DIV) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] c, input logic [15:0] d);
        bus.snd_cmd = 1'b1;
        bus.cmd     = c;
        bus.data    = d;
        @(negedge clk);
        bus.snd_cmd = 1'b0;
        bus.cmd     = 8'h5E;
        bus.data    = 16'hDEAD;
    endtask

    task automatic check_wire(input string tag, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        check({tag, "_nbytes"}, wire_q.size(), 3);
        check({tag, "_byte0"}, byte_at(0), b0);
        check({tag, "_byte1"}, byte_at(1), b1);
        check({tag, "_byte2"}, byte_at(2), b2);
    endtask

    initial begin
        vec_t vecs[4];
        int cyc;
        vecs[0] = '{8'hA5, 16'h1234, 1'b1, 8'h0A, 8'hA5, 8'h12, 8'h34, 8'h0A, 1'b1, 1'b0};
        vecs[1] = '{8'h3C, 16'h00FF, 1'b1, 8'hC3, 8'h3C, 8'h00, 8'hFF, 8'hC3, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 16'h8001, 1'b0, 8'h00, 8'hFF, 8'h80, 8'h01, 8'hC3, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 16'hFFFF, 1'b1, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0};

        bus.snd_cmd = 1'b0;
        bus.cmd = '0;
        bus.data = '0;
        bus.clr_resp_rdy = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_cmd_sent", bus.cmd_sent, 0);
        check("rst_resp", bus.resp, 8'h00);
        check("rst_resp_rdy", bus.resp_rdy, 0);
        check("rst_timeout", bus.timeout, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            wire_q.delete();
            send_cmd(vecs[i].cmd, vecs[i].data);
            check($sformatf("v%0d_start_bit", i), tx, 0);
            check($sformatf("v%0d_busy", i), bus.busy, 1);
            check($sformatf("v%0d_cmd_sent_clr", i), bus.cmd_sent, 0);
            check($sformatf("v%0d_resp_rdy_clr", i), bus.resp_rdy, 0);
            check($sformatf("v%0d_timeout_clr", i), bus.timeout, 0);
            wait_for(0, 40 * BAUD_DIV, $sformatf("v%0d_cmd_sent", i), cyc);
            check_wire($sformatf("v%0d", i), vecs[i].w0, vecs[i].w1, vecs[i].w2);
            if (vecs[i].do_resp) begin
                send_rx(vecs[i].rx_byte);
                wait_for(1, 20 * BAUD_DIV, $sformatf("v%0d_resp_rdy", i), cyc);
            end else begin
                wait_for(2, 2 * RESP_TIMEOUT, $sformatf("v%0d_timeout", i), cyc);
                check($sformatf("v%0d_timeout_latency", i), cyc, RESP_TIMEOUT);
            end
            check($sformatf("v%0d_resp", i), bus.resp, vecs[i].exp_resp);
            check($sformatf("v%0d_resp_rdy", i), bus.resp_rdy, vecs[i].exp_rdy);
            check($sformatf("v%0d_timeout_flag", i), bus.timeout, vecs[i].exp_tmo);
            check($sformatf("v%0d_idle", i), bus.busy, 0);
            if (vecs[i].exp_rdy) begin
                bus.clr_resp_rdy = 1'b1;
                @(negedge clk);
                bus.clr_resp_rdy = 1'b0;
                check($sformatf("v%0d_resp_rdy_ack", i), bus.resp_rdy, 0);
                check($sformatf("v%0d_resp_hold", i), bus.resp, vecs[i].exp_resp);
            end
            repeat (5) @(negedge clk);
        end

        // Request during SEND_HI must be dropped
        wire_q.delete();
        send_cmd(8'hC7, 16'hBEEF);
        wait_for(3, 20 * BAUD_DIV, "busy_first_byte", cyc);
        repeat (2 * BAUD_DIV) @(negedge clk);
        check("busy_in_send_hi", bus.busy, 1);
        send_cmd(8'h11, 16'h2222);
        wait_for(0, 40 * BAUD_DIV, "busy_cmd_sent", cyc);
        wait_for(2, 2 * RESP_TIMEOUT, "busy_timeout", cyc);
        repeat (12 * BAUD_DIV) @(negedge clk);
        check_wire("busy", 8'hC7, 8'hBE, 8'hEF);
        check("busy_resp_kept", bus.resp, 8'h00);

        // Stray byte while sending must not become the response
        wire_q.delete();
        send_cmd(8'h22, 16'h3344);
        check("stray_timeout_clr", bus.timeout, 0);
        send_rx(8'hFF);
        check("stray_resp_rdy", bus.resp_rdy, 0);
        check("stray_resp", bus.resp, 8'h00);
        wait_for(0, 40 * BAUD_DIV, "stray_cmd_sent", cyc);
        check("stray_resp_rdy_sent", bus.resp_rdy, 0);
        send_rx(8'h5A);
        wait_for(1, 20 * BAUD_DIV, "stray_resp_rdy_real", cyc);
        check("stray_resp_real", bus.resp, 8'h5A);

        // Reset in the middle of SEND_HI
        wire_q.delete();
        send_cmd(8'hA5, 16'h1234);
        wait_for(3, 20 * BAUD_DIV, "rst_first_byte", cyc);
        repeat (2 * BAUD_DIV) @(negedge clk);
        check("mid_busy", bus.busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_tx", tx, 1);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_cmd_sent", bus.cmd_sent, 0);
        check("mid_rst_resp", bus.resp, 8'h00);
        check("mid_rst_resp_rdy", bus.resp_rdy, 0);
        check("mid_rst_timeout", bus.timeout, 0);
        rst_n = 1'b1;
        repeat (12 * BAUD_DIV) @(negedge clk);
        check("post_rst_tx_idle", tx, 1);
        wire_q.delete();
        send_cmd(8'h81, 16'h0F0F);
        wait_for(0, 40 * BAUD_DIV, "post_rst_cmd_sent", cyc);
        check_wire("post_rst", 8'h81, 8'h0F, 8'h0F);
        send_rx(8'h7E);
        wait_for(1, 20 * BAUD_DIV, "post_rst_resp_rdy", cyc);
        check("post_rst_resp", bus.resp, 8'h7E);
        check("post_rst_idle", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
